// File: rtl/adpll_pkg.sv
// Purpose: shared ADPLL lock-detect state encodings and saturating magnitude helper.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
// Contents: adpll_state_t (ST_IDLE..ST_HOLDOVER), sat_abs().
package adpll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_HOLDOVER = 2'd3
  } adpll_state_t;

  // |val| for a two's-complement value of 'width' bits (width <= 31), already
  // sign-extended to 32 bits. The most-negative code clamps to the largest
  // positive code so the result always fits back into 'width' bits.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] val,
                                          input int unsigned        width);
    logic [31:0] max_mag;
    logic [31:0] mag;
    max_mag = (32'd1 << (width - 1)) - 32'd1;
    mag     = val[31] ? 32'(-val) : 32'(val);
    if (mag > max_mag) mag = max_mag;
    return mag;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Purpose: 2-flop synchroniser for an asynchronous input plus rising-edge strobe.
// Latency: rise first sampled at edge k gives strobe_o high after edge k+2.
// Backpressure: none; input must stay high/low >= 2 cycles so strobes never merge.
// Ports: fpga_clk_i, reset_i (sync, active-high), async_i (async level), strobe_o (1-cycle pulse).
module edge_sync (
  input  logic fpga_clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic strobe_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic strobe_q;

  // Strobe is registered so every downstream consumer sees a clean flop output.
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      sync1_q  <= async_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      strobe_q <= sync2_q & ~prev_q;
    end
  end

  assign strobe_o = strobe_q;

endmodule

// File: rtl/adpll_lock_detect.sv
// Purpose: debounced ADPLL lock detector with peak-error tracking and slip counter.
// Latency: ref rise sampled at edge k -> state/outputs update at edge k+3.
// Backpressure: none; one error sample consumed per reference rising edge.
// Ports: fpga_clk_i, reset_i, enable_i, ref_clk_i (async), error_i (signed) ->
//        locked_o, state_o, lock_lost_o (pulse), peak_error_o, slip_count_o.
module adpll_lock_detect
  import adpll_pkg::*;
#(
  parameter int unsigned ERR_WIDTH     = 8,
  parameter int unsigned LOCK_THRESH   = 2,
  parameter int unsigned UNLOCK_THRESH = 6,
  parameter int unsigned LOCK_COUNT    = 64,
  parameter int unsigned UNLOCK_COUNT  = 4,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                 fpga_clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic                 ref_clk_i,
  input  logic [ERR_WIDTH-1:0] error_i,
  output logic                 locked_o,
  output logic [1:0]           state_o,
  output logic                 lock_lost_o,
  output logic [ERR_WIDTH-1:0] peak_error_o,
  output logic [7:0]           slip_count_o
);

  logic                 strobe;
  logic [ERR_WIDTH-1:0] err_q;
  logic [31:0]          mag_full;
  logic [ERR_WIDTH-1:0] mag;
  logic [ERR_WIDTH-1:0] peak_max;
  logic                 good;
  logic                 bad;

  adpll_state_t         state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 lock_hit;
  logic                 unlock_hit;
  logic [ERR_WIDTH-1:0] peak_q, peak_d;
  logic [7:0]           slip_q, slip_d;
  logic                 locked_q, locked_d;
  logic                 lost_q, lost_d;

  edge_sync u_ref_sync (
    .fpga_clk_i (fpga_clk_i),
    .reset_i    (reset_i),
    .async_i    (ref_clk_i),
    .strobe_o   (strobe)
  );

  // The error bus is registered every cycle; the copy present while the
  // strobe is high is the sample for that reference edge.
  assign mag_full = sat_abs(32'($signed(err_q)), ERR_WIDTH);
  assign mag      = mag_full[ERR_WIDTH-1:0];
  assign good     = (mag_full <= LOCK_THRESH);
  assign bad      = (mag_full >  UNLOCK_THRESH);
  assign peak_max = (mag > peak_q) ? mag : peak_q;

  // Targets are below 2^CNT_WIDTH, so the counter stops at its target and
  // cnt_inc never wraps.
  assign cnt_inc    = cnt_q + CNT_WIDTH'(1);
  assign lock_hit   = (cnt_inc == CNT_WIDTH'(LOCK_COUNT));
  assign unlock_hit = (cnt_inc == CNT_WIDTH'(UNLOCK_COUNT));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    peak_d  = peak_q;
    slip_d  = slip_q;
    lost_d  = 1'b0;

    if (!enable_i) begin
      // Disable wins over any strobe; peak and slip history are kept.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQUIRE;
          cnt_d   = '0;
        end

        ST_ACQUIRE: begin
          if (strobe) begin
            if (good) begin
              if (lock_hit) begin
                state_d = ST_LOCKED;
                cnt_d   = '0;
                peak_d  = mag;
              end else begin
                cnt_d = cnt_inc;
              end
            end else begin
              cnt_d = '0;
            end
          end
        end

        ST_LOCKED: begin
          if (strobe) begin
            peak_d = peak_max;
            if (bad) begin
              if (unlock_hit) begin
                // Single-sample unlock: skip HOLDOVER entirely.
                state_d = ST_ACQUIRE;
                cnt_d   = '0;
                lost_d  = 1'b1;
                slip_d  = (slip_q == 8'hFF) ? slip_q : slip_q + 8'd1;
              end else begin
                state_d = ST_HOLDOVER;
                cnt_d   = CNT_WIDTH'(1);
              end
            end
          end
        end

        ST_HOLDOVER: begin
          if (strobe) begin
            peak_d = peak_max;
            if (bad) begin
              if (unlock_hit) begin
                state_d = ST_ACQUIRE;
                cnt_d   = '0;
                lost_d  = 1'b1;
                slip_d  = (slip_q == 8'hFF) ? slip_q : slip_q + 8'd1;
              end else begin
                cnt_d = cnt_inc;
              end
            end else begin
              state_d = ST_LOCKED;
              cnt_d   = '0;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED) || (state_d == ST_HOLDOVER);
  end

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      err_q    <= '0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      peak_q   <= '0;
      slip_q   <= '0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      err_q    <= error_i;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      peak_q   <= peak_d;
      slip_q   <= slip_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
    end
  end

  assign locked_o     = locked_q;
  assign state_o      = state_q;
  assign lock_lost_o  = lost_q;
  assign peak_error_o = peak_q;
  assign slip_count_o = slip_q;

endmodule

// File: tb/tb_adpll_lock_detect.sv
module tb_adpll_lock_detect;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default parameters)
  logic       rst, en, refc;
  logic [7:0] err;
  logic       locked, lost;
  logic [1:0] st;
  logic [7:0] peak, slip;

  // Fast-cycling instance for slip saturation
  logic       rst2, en2, ref2;
  logic [7:0] err2;
  logic       locked2, lost2;
  logic [1:0] st2;
  logic [7:0] peak2, slip2;

  adpll_lock_detect dut (
    .fpga_clk_i   (clk),
    .reset_i      (rst),
    .enable_i     (en),
    .ref_clk_i    (refc),
    .error_i      (err),
    .locked_o     (locked),
    .state_o      (st),
    .lock_lost_o  (lost),
    .peak_error_o (peak),
    .slip_count_o (slip)
  );

  adpll_lock_detect #(.LOCK_COUNT(1), .UNLOCK_COUNT(1)) dut2 (
    .fpga_clk_i   (clk),
    .reset_i      (rst2),
    .enable_i     (en2),
    .ref_clk_i    (ref2),
    .error_i      (err2),
    .locked_o     (locked2),
    .state_o      (st2),
    .lock_lost_o  (lost2),
    .peak_error_o (peak2),
    .slip_count_o (slip2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [19:0] val;
  } exp_t;

  exp_t        q[$];
  logic [9:0]  q2[$];
  logic [19:0] prev = 20'h0;
  logic [19:0] cur1;
  exp_t        e1;
  logic [9:0]  e2;

  function automatic logic [19:0] pk(input logic [1:0] s, input logic l, input logic ll,
                                     input logic [7:0] p, input logic [7:0] sl);
    return {s, l, ll, p, sl};
  endfunction

  // Expect the output vector to become v at posedge number cyc+d.
  task automatic expect_at(input int d, input logic [19:0] v);
    exp_t e;
    e.cyc = cyc + d;
    e.val = v;
    q.push_back(e);
  endtask

  // Monitor: every change of the main instance's outputs must match the
  // next scoreboard entry in both value and cycle.
  always @(negedge clk) begin
    cur1 = {st, locked, lost, peak, slip};
    if (cur1 !== prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got=%h", cyc, cur1);
      end else begin
        e1 = q.pop_front();
        if (e1.cyc != cyc || e1.val !== cur1) begin
          errors++;
          $display("FAIL output_change got cyc=%0d val=%h required cyc=%0d val=%h",
                   cyc, cur1, e1.cyc, e1.val);
        end
      end
      prev = cur1;
    end
  end

  // Monitor: each lock_lost pulse of the second instance carries {state, slip}.
  always @(negedge clk) begin
    if (lost2 === 1'b1) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse2 cyc=%0d st=%0d slip=%0d", cyc, st2, slip2);
      end else begin
        e2 = q2.pop_front();
        if ({st2, slip2} !== e2) begin
          errors++;
          $display("FAIL pulse2 got st=%0d slip=%0d required st=%0d slip=%0d",
                   st2, slip2, e2[9:8], e2[7:0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One reference period of 4 cycles; the resulting update lands 4 edges later.
  task automatic sample(input logic [7:0] e, input bit drop_en);
    refc = 1'b1;
    err  = e;
    tick;
    tick;
    refc = 1'b0;
    tick;
    if (drop_en) en = 1'b0;
    tick;
  endtask

  task automatic sample2(input logic [7:0] e);
    ref2 = 1'b1;
    err2 = e;
    tick;
    tick;
    ref2 = 1'b0;
    tick;
    tick;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] sl;
    rst = 1'b1; en = 1'b0; refc = 1'b0; err = 8'd0;
    rst2 = 1'b1; en2 = 1'b0; ref2 = 1'b0; err2 = 8'd0;
    repeat (3) tick;
    rst = 1'b0; rst2 = 1'b0;
    tick;

    checks++;
    if ({st, locked, lost, peak, slip} !== 20'h0) begin
      errors++;
      $display("FAIL reset_state got=%h required=%h", {st, locked, lost, peak, slip}, 20'h0);
    end

    // Acquisition interrupted by one sample of 3, then 64 more good samples
    expect_at(1, pk(2'd1, 1'b0, 1'b0, 8'd0, 8'd0));
    en = 1'b1;
    tick;
    for (int i = 0; i < 40; i++) sample(8'd1, 1'b0);
    sample(8'd3, 1'b0);
    for (int i = 1; i <= 64; i++) begin
      if (i == 64) expect_at(4, pk(2'd2, 1'b1, 1'b0, 8'd1, 8'd0));
      sample(8'd1, 1'b0);
    end

    // Three +7 samples: holdover, then recovery without loss
    expect_at(4, pk(2'd3, 1'b1, 1'b0, 8'd7, 8'd0));
    sample(8'd7, 1'b0);
    sample(8'd7, 1'b0);
    sample(8'd7, 1'b0);
    expect_at(4, pk(2'd2, 1'b1, 1'b0, 8'd7, 8'd0));
    sample(8'd0, 1'b0);

    // Four -128 samples: loss of lock, single pulse, peak saturates at 127
    expect_at(4, pk(2'd3, 1'b1, 1'b0, 8'd127, 8'd0));
    sample(8'h80, 1'b0);
    sample(8'h80, 1'b0);
    sample(8'h80, 1'b0);
    expect_at(4, pk(2'd1, 1'b0, 1'b1, 8'd127, 8'd1));
    expect_at(5, pk(2'd1, 1'b0, 1'b0, 8'd127, 8'd1));
    sample(8'h80, 1'b0);

    // Error held at 0: lock on the 64th sample, peak reloaded with 0
    for (int i = 1; i <= 64; i++) begin
      if (i == 64) expect_at(4, pk(2'd2, 1'b1, 1'b0, 8'd0, 8'd1));
      sample(8'd0, 1'b0);
    end

    // Enter holdover, then drop enable on the same edge as a bad strobe
    expect_at(4, pk(2'd3, 1'b1, 1'b0, 8'd10, 8'd1));
    sample(8'd10, 1'b0);
    expect_at(4, pk(2'd0, 1'b0, 1'b0, 8'd10, 8'd1));
    sample(8'hF6, 1'b1);
    tick;
    expect_at(1, pk(2'd1, 1'b0, 1'b0, 8'd10, 8'd1));
    en = 1'b1;
    tick;

    // Threshold boundaries: |-2| is good, 6 and -6 are not bad
    for (int i = 1; i <= 64; i++) begin
      if (i == 64) expect_at(4, pk(2'd2, 1'b1, 1'b0, 8'd2, 8'd1));
      sample(8'hFE, 1'b0);
    end
    expect_at(4, pk(2'd2, 1'b1, 1'b0, 8'd6, 8'd1));
    sample(8'd6, 1'b0);
    sample(8'hFA, 1'b0);

    // Reset while locked clears everything including slip count
    expect_at(1, pk(2'd0, 1'b0, 1'b0, 8'd0, 8'd0));
    rst = 1'b1;
    tick;
    tick;
    en = 1'b0;
    rst = 1'b0;
    tick;
    tick;

    // 300 lock/loss cycles on the single-sample instance
    en2 = 1'b1;
    tick;
    for (int i = 1; i <= 300; i++) begin
      sample2(8'd0);
      sl = (i > 255) ? 8'd255 : 8'(i);
      q2.push_back({2'd1, sl});
      sample2(8'd127);
    end
    repeat (4) tick;

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_changes got=%0d pending required=0", q.size());
    end
    checks++;
    if (q2.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses2 got=%0d pending required=0", q2.size());
    end
    checks++;
    if (slip2 !== 8'd255) begin
      errors++;
      $display("FAIL slip_saturate got=%0d required=255", slip2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adpll_lock_detect.md
# adpll_lock_detect

Lock detector that sits directly downstream of the ADPLL. It consumes the loop's signed phase error once per reference-clock rising edge and qualifies it into a debounced `locked_o` for the board LEDs. It also tracks peak error while locked and counts lock losses for the display path. Hysteresis on both threshold and duration prevents LED chatter while the loop settles.

## Interface
Parameters:
- `ERR_WIDTH`, 8: width of the signed error input.
- `LOCK_THRESH`, 2: max |error| counted as "good" while acquiring.
- `UNLOCK_THRESH`, 6: |error| above this counts as "bad" while locked. Must be ≥ `LOCK_THRESH`.
- `LOCK_COUNT`, 64: consecutive good samples needed to declare lock. Range 1..2^`CNT_WIDTH`-1.
- `UNLOCK_COUNT`, 4: consecutive bad samples needed to declare loss of lock. Range 1..2^`CNT_WIDTH`-1.
- `CNT_WIDTH`, 8: width of the qualification counter.

Ports:
- `fpga_clk_i`, in, 1: single clock (258 MHz loop clock).
- `reset_i`, in, 1: synchronous, active-high reset.
- `enable_i`, in, 1: when low, forces IDLE.
- `ref_clk_i`, in, 1: reference clock, treated as asynchronous.
- `error_i`, in, `ERR_WIDTH`: signed two's-complement phase error from the ADPLL.
- `locked_o`, out, 1: high in LOCKED and HOLDOVER.
- `state_o`, out, 2: current state. IDLE=0, ACQUIRE=1, LOCKED=2, HOLDOVER=3.
- `lock_lost_o`, out, 1: one-cycle pulse on each HOLDOVER→ACQUIRE transition.
- `peak_error_o`, out, `ERR_WIDTH`: unsigned max |error| since lock was last declared.
- `slip_count_o`, out, 8: saturating count of lock losses.

## Operation
Sampling:
- `ref_clk_i` passes through a 2-flop synchroniser, then a rising-edge detector that produces a one-cycle `strobe`.
- `error_i` is registered on every cycle. The value captured on the strobe cycle is the sample.
- Magnitude is |error|. The most-negative code (-128 at width 8) saturates to 127.
- good = mag ≤ `LOCK_THRESH`. bad = mag > `UNLOCK_THRESH`.

States (all transitions occur only on a strobe cycle, except the IDLE rules):
- IDLE: goes to ACQUIRE on the first cycle `enable_i`=1. Qualification counter cleared.
- ACQUIRE: a good sample increments the counter; any other sample clears it to 0. When the counter would reach `LOCK_COUNT`, go to LOCKED, clear the counter and load `peak_error_o` = current mag.
- LOCKED: `peak_error_o` = max(peak, mag) on every sample. A bad sample sets the counter to 1 and goes to HOLDOVER; if `UNLOCK_COUNT`=1, it goes directly to ACQUIRE with the loss actions below.
- HOLDOVER: `peak_error_o` continues to update. A bad sample increments the counter. A non-bad sample clears the counter and returns to LOCKED. When the counter reaches `UNLOCK_COUNT`, go to ACQUIRE, pulse `lock_lost_o`, increment `slip_count_o` (saturating at 255) and clear the counter.

Boundary rules:
- `enable_i`=0 takes priority over any strobe: next state IDLE, counter cleared, `lock_lost_o` not pulsed. `peak_error_o` and `slip_count_o` are retained.
- Reset mid-operation clears everything on the next edge, including synchroniser flops and `slip_count_o`.
- The qualification counter never exceeds its target; no wrap-around.

## Timing
- Reset values: `locked_o`=0, `state_o`=0, `lock_lost_o`=0, `peak_error_o`=0, `slip_count_o`=0. Synchroniser and edge-detect flops = 0.
- A `ref_clk_i` rise first sampled at edge k asserts `strobe` after edge k+2. The sample is `error_i` as registered at edge k+2. State and outputs update at edge k+3.
- All outputs are registered. `locked_o`, `lock_lost_o` and `slip_count_o` change on the same edge as `state_o`.
- Maximum supported ref frequency is `fpga_clk_i`/4, so the edge detector never merges strobes.

## Structure
- A shared package/include `adpll_pkg` holds the state encodings (`ST_IDLE`..`ST_HOLDOVER`) and the saturating-abs function. The same constants are reused by the display path.
- One sub-module, `edge_sync`: 2-flop synchroniser plus rising-edge strobe, with ports `fpga_clk_i`, `reset_i`, `async_i` and `strobe_o`. It is reusable for the external reference input.
- The state machine, counters, peak tracker and slip counter live in the top module.

## Test plan
- Error held at 0, 64 ref edges → `locked_o` rises exactly on the 64th strobe+1 edge; `state_o`=2.
- Acquiring with error 1 for 40 samples, one sample of 3, then 1 thereafter → counter restarts; lock is declared 64 samples after the 3.
- Locked, 3 consecutive samples of +7 then one of 0 → HOLDOVER for 3 samples, back to LOCKED. No `lock_lost_o`; `slip_count_o` unchanged; `peak_error_o`=7.
- Locked, 4 consecutive samples of -128 → `lock_lost_o` is a single pulse, `state_o`=1, `slip_count_o`=1, `peak_error_o`=127.
- `enable_i` dropped mid-HOLDOVER coincident with a bad strobe → IDLE next edge with no pulse. `reset_i` mid-LOCKED → all outputs zero next edge.
- 300 forced lock/loss cycles → `slip_count_o` saturates at 255.
